aliens_bus_seq: RTL and testbench

ALIENS_BUS_SEQ -- requirements
Module: aliens_bus_seq

---
 rtl/aliens_bus_seq.sv | 207 ++++++++++++++++++++
 tb/tb_aliens_bus_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aliens_bus_seq.sv
// aliens_bus_seq
// CPU bus cycle sequencer for the Aliens memory map. Each CPU cycle starts
// when the address strobe is seen in IDLE. The address is decoded into one of
// four regions, the matching chip select is raised, and the region's wait
// states are counted off. The cycle is then acknowledged with rdy until the
// CPU drops the strobe. Two I/O addresses hold the ROM bank register
// (0x5F80) and the work/palette overlay bit (0x5F88).
//
// Ports
//   clk      in   1   system clock
//   reset    in   1   synchronous active-high reset
//   as       in   1   CPU address strobe, cycle active while high
//   addr     in  16   CPU address
//   rw       in   1   1 = read, 0 = write
//   wdata    in   8   CPU write data
//   cs_work  out  1   work RAM select    (0x0000-0x1FFF)
//   cs_bank  out  1   banked ROM select  (0x2000-0x3FFF)
//   cs_prog  out  1   program ROM select (0x8000-0xFFFF)
//   cs_io    out  1   I/O select         (0x4000-0x7FFF)
//   rdy      out  1   cycle-complete acknowledge
//   bank     out  5   ROM bank register
//   init     out  1   work/palette overlay select (WOCO source)

module aliens_bus_seq #(
    parameter int WS_WORK = 0,
    parameter int WS_BANK = 2,
    parameter int WS_PROG = 1,
    parameter int WS_IO   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic        cs_work,
    output logic        cs_bank,
    output logic        cs_prog,
    output logic        cs_io,
    output logic        rdy,
    output logic [4:0]  bank,
    output logic        init
);

    localparam int CW = 8;

    localparam logic [15:0] BANK_REG_ADDR = 16'h5F80;
    localparam logic [15:0] INIT_REG_ADDR = 16'h5F88;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        REG_WORK,
        REG_BANK,
        REG_IO,
        REG_PROG
    } region_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [15:0]     addr_q;
    logic            rw_q;
    region_t         region_q;
    region_t         region_dec;
    logic            armed;
    logic            armed_next;
    logic            start;
    logic [3:0]      cs_next;
    logic            rdy_next;
    logic            wr_bank;
    logic            wr_init;
    logic            unused_wdata;

    // Only bits 5:0 of the write data feed a register.
    assign unused_wdata = ^wdata[7:6];

    // Address decode on the live bus; only used on the edge a cycle starts,
    // after that the latched region is authoritative.
    always_comb begin
        region_dec = REG_WORK;
        if (addr[15])
            region_dec = REG_PROG;
        else if (addr[14])
            region_dec = REG_IO;
        else if (addr[13])
            region_dec = REG_BANK;
        else
            region_dec = REG_WORK;
    end

    // State register plus every registered output. Reset wins over anything
    // else sampled on the same edge, so a cycle in flight is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b1;
            region_q <= REG_WORK;
            armed    <= 1'b1;
            cs_work  <= 1'b0;
            cs_bank  <= 1'b0;
            cs_prog  <= 1'b0;
            cs_io    <= 1'b0;
            rdy      <= 1'b0;
            bank     <= '0;
            init     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            armed <= armed_next;
            if (start) begin
                addr_q   <= addr;
                rw_q     <= rw;
                region_q <= region_dec;
            end
            cs_work <= cs_next[0];
            cs_bank <= cs_next[1];
            cs_prog <= cs_next[2];
            cs_io   <= cs_next[3];
            rdy     <= rdy_next;
            if (wr_bank)
                bank <= wdata[4:0];
            if (wr_init)
                init <= wdata[5];
        end
    end

    // Next-state logic. A cycle only starts once the sequencer is armed,
    // which means the strobe has been seen low in IDLE since the last cycle
    // ended; reset leaves it armed so a strobe held through reset release
    // starts immediately. Dropping the strobe during WAIT aborts the cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        armed_next = armed;
        case (state)
            IDLE: begin
                if (as && armed) begin
                    start      = 1'b1;
                    state_next = WAIT;
                    case (region_dec)
                        REG_WORK: cnt_next = CW'(WS_WORK);
                        REG_BANK: cnt_next = CW'(WS_BANK);
                        REG_IO:   cnt_next = CW'(WS_IO);
                        REG_PROG: cnt_next = CW'(WS_PROG);
                        default:  cnt_next = '0;
                    endcase
                end else if (!as) begin
                    armed_next = 1'b1;
                end
            end
            WAIT: begin
                if (!as) begin
                    state_next = IDLE;
                    armed_next = 1'b0;
                end else if (cnt == '0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ACK: begin
                if (!as) begin
                    state_next = IDLE;
                    armed_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered selects and rdy, and the
    // register write strobes. The starting edge uses the live decode since
    // the latched region is not loaded yet. Register writes fire only on
    // the WAIT->ACK edge of a write, using the data on the bus at that edge.
    always_comb begin
        cs_next  = 4'b0000;
        rdy_next = 1'b0;
        wr_bank  = 1'b0;
        wr_init  = 1'b0;
        if (state_next != IDLE) begin
            case (start ? region_dec : region_q)
                REG_WORK: cs_next = 4'b0001;
                REG_BANK: cs_next = 4'b0010;
                REG_PROG: cs_next = 4'b0100;
                REG_IO:   cs_next = 4'b1000;
                default:  cs_next = 4'b0000;
            endcase
        end
        rdy_next = (state_next == ACK);
        if (state == WAIT && state_next == ACK && !rw_q) begin
            wr_bank = (addr_q == BANK_REG_ADDR);
            wr_init = (addr_q == INIT_REG_ADDR);
        end
    end

endmodule

// File: tb/tb_aliens_bus_seq.sv
// tb_aliens_bus_seq
// Self-checking bench for aliens_bus_seq. Each bus cycle pushes its expected
// outcome (select pattern, rdy latency, register contents) into a scoreboard
// queue; the entry is popped and compared when the DUT acknowledges.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_aliens_bus_seq;

    localparam int WS_WORK = 0;
    localparam int WS_BANK = 2;
    localparam int WS_PROG = 1;
    localparam int WS_IO   = 3;

    logic        clk;
    logic        reset;
    logic        as;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        cs_work;
    logic        cs_bank;
    logic        cs_prog;
    logic        cs_io;
    logic        rdy;
    logic [4:0]  bank;
    logic        init;

    logic [3:0]  obs_cs;

    typedef struct {
        logic [3:0] cs;
        int         lat;
        logic [4:0] bank;
        logic       init;
    } exp_t;

    exp_t sb[$];

    int          checks;
    int          failures;
    logic [4:0]  bank_model;
    logic        init_model;

    aliens_bus_seq #(
        .WS_WORK (WS_WORK),
        .WS_BANK (WS_BANK),
        .WS_PROG (WS_PROG),
        .WS_IO   (WS_IO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .as      (as),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .cs_work (cs_work),
        .cs_bank (cs_bank),
        .cs_prog (cs_prog),
        .cs_io   (cs_io),
        .rdy     (rdy),
        .bank    (bank),
        .init    (init)
    );

    assign obs_cs = {cs_io, cs_prog, cs_bank, cs_work};

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected select pattern {io, prog, bank, work} from the memory map.
    function automatic logic [3:0] region_cs(input logic [15:0] a);
        if (a >= 16'h8000)
            return 4'b0100;
        else if (a >= 16'h4000)
            return 4'b1000;
        else if (a >= 16'h2000)
            return 4'b0010;
        else
            return 4'b0001;
    endfunction

    // Expected wait states for an address.
    function automatic int region_ws(input logic [15:0] a);
        if (a >= 16'h8000)
            return WS_PROG;
        else if (a >= 16'h4000)
            return WS_IO;
        else if (a >= 16'h2000)
            return WS_BANK;
        else
            return WS_WORK;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete bus cycle. a_late replaces the address one cycle after
    // the start edge so latching can be exercised; the expected outcome is
    // always derived from the original address.
    task automatic applyStimulus(input logic [15:0] a, input logic r,
                                 input logic [7:0] wd, input logic [15:0] a_late);
        exp_t e;
        int   n;
        logic [3:0] cs_seen;
        logic cs_moved;
        e.cs  = region_cs(a);
        e.lat = region_ws(a) + 1;
        if (!r && a == 16'h5F80) bank_model = wd[4:0];
        if (!r && a == 16'h5F88) init_model = wd[5];
        e.bank = bank_model;
        e.init = init_model;
        sb.push_back(e);

        @(negedge clk);
        as = 1'b1; addr = a; rw = r; wdata = wd;
        @(negedge clk);
        cs_seen  = obs_cs;
        cs_moved = 1'b0;
        addr     = a_late;
        n        = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            if (obs_cs !== cs_seen) cs_moved = 1'b1;
        end
        e = sb.pop_front();
        checkOutput($sformatf("cs_start@%h", a), {28'd0, cs_seen}, {28'd0, e.cs});
        checkOutput($sformatf("rdy_latency@%h", a), n, e.lat);
        checkOutput($sformatf("cs_stable@%h", a), {31'd0, cs_moved}, 32'd0);
        checkOutput($sformatf("bank@%h", a), {27'd0, bank}, {27'd0, e.bank});
        checkOutput($sformatf("init@%h", a), {31'd0, init}, {31'd0, e.init});
        @(negedge clk);
        checkOutput($sformatf("ack_hold@%h", a), {27'd0, obs_cs, rdy}, {27'd0, e.cs, 1'b1});
        as = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("release@%h", a), {27'd0, obs_cs, rdy}, 32'd0);
        @(negedge clk);
    endtask

    // A write cycle whose strobe is dropped during the wait states.
    task automatic applyAbort(input logic [15:0] a, input logic [7:0] wd);
        logic rdy_seen;
        @(negedge clk);
        as = 1'b1; addr = a; rw = 1'b0; wdata = wd;
        @(negedge clk);
        checkOutput("abort_cs_start", {28'd0, obs_cs}, {28'd0, region_cs(a)});
        as = 1'b0;
        @(negedge clk);
        checkOutput("abort_cs_drop", {28'd0, obs_cs}, 32'd0);
        rdy_seen = rdy;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rdy_seen = rdy_seen | rdy;
        end
        checkOutput("abort_no_rdy", {31'd0, rdy_seen}, 32'd0);
        checkOutput("abort_bank", {27'd0, bank}, {27'd0, bank_model});
    endtask

    // Reset in the ACK phase of a bank write, then restart with the strobe
    // held high across reset release.
    task automatic applyResetInAck();
        int n;
        @(negedge clk);
        as = 1'b1; addr = 16'h5F80; rw = 1'b0; wdata = 8'h05;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_pre_bank", {27'd0, bank}, 32'h05);
        reset = 1'b1;
        @(negedge clk);
        bank_model = 5'd0;
        init_model = 1'b0;
        checkOutput("rst_outputs", {25'd0, obs_cs, rdy, bank, init},
                    {25'd0, 4'b0000, 1'b0, bank_model, init_model});
        addr  = 16'h0100;
        rw    = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_restart_cs", {28'd0, obs_cs}, 32'h1);
        checkOutput("rst_restart_rdy_low", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        checkOutput("rst_restart_rdy", {31'd0, rdy}, 32'd1);
        as = 1'b0;
        @(negedge clk);
        checkOutput("rst_restart_release", {27'd0, obs_cs, rdy}, 32'd0);
        @(negedge clk);
    endtask

    // Main sequence.
    initial begin
        logic [15:0] ra;
        checks     = 0;
        failures   = 0;
        bank_model = 5'd0;
        init_model = 1'b0;
        reset = 1'b1;
        as    = 1'b1;
        addr  = 16'h0000;
        rw    = 1'b1;
        wdata = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {25'd0, obs_cs, rdy, bank, init}, 32'd0);
        as    = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(16'h0100, 1'b1, 8'h00, 16'h0100);
        applyStimulus(16'hC000, 1'b1, 8'h00, 16'hC000);
        applyStimulus(16'h2345, 1'b1, 8'h00, 16'h2345);
        applyStimulus(16'h4000, 1'b1, 8'h00, 16'h4000);
        applyStimulus(16'h1FFF, 1'b1, 8'h00, 16'h1FFF);
        applyStimulus(16'h7FFF, 1'b1, 8'h00, 16'h7FFF);

        applyStimulus(16'h5F80, 1'b0, 8'hFF, 16'h5F80);
        applyStimulus(16'h5F88, 1'b0, 8'h20, 16'h5F88);
        applyStimulus(16'h5F80, 1'b1, 8'h03, 16'h5F80);
        applyStimulus(16'h5F88, 1'b0, 8'hDF, 16'h5F88);
        applyStimulus(16'h1000, 1'b0, 8'h55, 16'h1000);

        applyAbort(16'h5F80, 8'h0A);

        applyStimulus(16'h0100, 1'b1, 8'h00, 16'h9000);

        applyResetInAck();

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            applyStimulus(ra, 1'b1, 8'($urandom), ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
